// File: rtl/servo_motion_sequencer.sv
// servo_motion_sequencer
//   Ramps per-channel servo angles toward command targets once per servo
//   frame and hands each new angle to the PWM drivers with a one-cycle
//   latch strobe.
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   enable         run the frame tick counter (low clears counter/pending)
//   cmd_valid/ready, cmd_ch, cmd_rot, cmd_immediate
//                  target command; immediate jumps cur to target at once
//   rotation       commanded angle, channel i on [8i+7:8i]
//   set_rotation   one-cycle latch strobe per channel
//   busy           channel i still ramping (cur != target)
//
// Build option
//   SERVO_SEQ_LIMIT_EN  clamp cmd_rot to [MIN_ROT, MAX_ROT] before use
module servo_motion_sequencer #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned STEP_TICKS = 1000000,
   parameter int unsigned STEP_SIZE  = 1,
   parameter int unsigned RESET_ROT  = 90,
   parameter int unsigned MIN_ROT    = 0,
   parameter int unsigned MAX_ROT    = 180,
   localparam int unsigned CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CW-1:0]         cmd_ch,
   input  logic [7:0]            cmd_rot,
   input  logic                  cmd_immediate,
   output logic [8*NUM_CH-1:0]   rotation,
   output logic [NUM_CH-1:0]     set_rotation,
   output logic [NUM_CH-1:0]     busy
);

   localparam int unsigned CNTW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
`ifdef SERVO_SEQ_LIMIT_EN
   localparam logic LIMIT_EN = 1'b1;
`else
   localparam logic LIMIT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {INIT, IDLE, SCAN, STROBE} state_t;

   state_t            state, state_n;
   logic [CW-1:0]     ch, ch_n;
   logic              imm, imm_n;
   logic [NUM_CH-1:0] strobe_n;
   logic [7:0]        cur    [NUM_CH];
   logic [7:0]        target [NUM_CH];
   logic [CNTW-1:0]   cnt;
   logic              pending, wrap, pend_clr;
   logic              cmd_acc, cmd_in_range, last_ch, cur_ne;
   logic              scan_wr;
   logic [7:0]        scan_val, rot_c;
   logic [8:0]        c9, t9, up9, dn9;

   function automatic logic [NUM_CH-1:0] onehot(input logic [CW-1:0] sel);
      logic [NUM_CH-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         v[i] = (sel == CW'(i));
      return v;
   endfunction

   function automatic logic [7:0] clamp_rot(input logic [7:0] r);
      if (LIMIT_EN && int'(r) < int'(MIN_ROT)) return 8'(MIN_ROT);
      if (LIMIT_EN && int'(r) > int'(MAX_ROT)) return 8'(MAX_ROT);
      return r;
   endfunction

   assign rot_c        = clamp_rot(cmd_rot);
   assign cmd_in_range = int'(cmd_ch) < int'(NUM_CH);
   assign last_ch      = (ch == CW'(NUM_CH - 1));
   assign wrap         = enable && (cnt == CNTW'(STEP_TICKS - 1));

   // Ramp arithmetic in 9 bits so a step can neither wrap past 255 nor below 0.
   always_comb begin
      c9       = {1'b0, cur[ch]};
      t9       = {1'b0, target[ch]};
      up9      = c9 + 9'(STEP_SIZE);
      dn9      = (c9 > 9'(STEP_SIZE)) ? (c9 - 9'(STEP_SIZE)) : '0;
      cur_ne   = (c9 != t9);
      scan_val = cur[ch];
      if (c9 < t9)
         scan_val = (up9 < t9) ? up9[7:0] : t9[7:0];
      else if (c9 > t9)
         scan_val = (dn9 > t9) ? dn9[7:0] : t9[7:0];
   end

   always_comb begin
      state_n   = state;
      ch_n      = ch;
      imm_n     = imm;
      strobe_n  = '0;
      cmd_ready = 1'b0;
      cmd_acc   = 1'b0;
      scan_wr   = 1'b0;
      pend_clr  = 1'b0;
      case (state)
         INIT: begin
            strobe_n = onehot(ch);
            if (last_ch) begin
               state_n = IDLE;
               ch_n    = '0;
            end else begin
               ch_n = ch + 1'b1;
            end
         end
         IDLE: begin
            cmd_ready = 1'b1;
            // A command always wins over a pending tick; the tick waits.
            if (cmd_valid) begin
               cmd_acc = 1'b1;
               if (cmd_in_range && cmd_immediate) begin
                  state_n  = STROBE;
                  ch_n     = cmd_ch;
                  imm_n    = 1'b1;
                  strobe_n = onehot(cmd_ch);
               end
            end else if (pending) begin
               state_n = SCAN;
               ch_n    = '0;
               imm_n   = 1'b0;
            end
         end
         SCAN: begin
            if (cur_ne) begin
               scan_wr  = 1'b1;
               state_n  = STROBE;
               strobe_n = onehot(ch);
            end else if (last_ch) begin
               state_n  = IDLE;
               ch_n     = '0;
               pend_clr = 1'b1;
            end else begin
               ch_n = ch + 1'b1;
            end
         end
         STROBE: begin
            if (imm) begin
               state_n = IDLE;
               imm_n   = 1'b0;
               ch_n    = '0;
            end else if (last_ch) begin
               state_n  = IDLE;
               ch_n     = '0;
               pend_clr = 1'b1;
            end else begin
               state_n = SCAN;
               ch_n    = ch + 1'b1;
            end
         end
         default: state_n = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= INIT;
         ch           <= '0;
         imm          <= 1'b0;
         set_rotation <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cur[i]    <= 8'(RESET_ROT);
            target[i] <= 8'(RESET_ROT);
         end
      end else begin
         state        <= state_n;
         ch           <= ch_n;
         imm          <= imm_n;
         set_rotation <= strobe_n;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cmd_acc && cmd_in_range && cmd_ch == CW'(i)) begin
               target[i] <= rot_c;
               if (cmd_immediate) cur[i] <= rot_c;
            end
            if (scan_wr && ch == CW'(i)) cur[i] <= scan_val;
         end
      end
   end

   // Frame tick: a wrap while a tick is already pending is absorbed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         pending <= 1'b0;
      end else if (!enable) begin
         cnt     <= '0;
         pending <= 1'b0;
      end else begin
         cnt <= wrap ? '0 : cnt + 1'b1;
         if (wrap)          pending <= 1'b1;
         else if (pend_clr) pending <= 1'b0;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         rotation[8*i +: 8] = cur[i];
         busy[i]            = (cur[i] != target[i]);
      end
   end

endmodule

// File: tb/tb_servo_motion_sequencer.sv
module tb_servo_motion_sequencer;

   logic        clk = 1'b0;
   logic        reset_n, enable, cmd_valid, cmd_immediate, cmd_ready;
   logic [1:0]  cmd_ch;
   logic [7:0]  cmd_rot;
   logic [31:0] rotation;
   logic [3:0]  set_rotation, busy;

   int checks = 0;
   int errors = 0;
   int sc [4] = '{0, 0, 0, 0};

`ifdef SERVO_SEQ_LIMIT_EN
   localparam logic [7:0] EXP_LIM = 8'd180;
`else
   localparam logic [7:0] EXP_LIM = 8'd200;
`endif

   servo_motion_sequencer #(
      .NUM_CH(4), .STEP_TICKS(10), .STEP_SIZE(4),
      .RESET_ROT(90), .MIN_ROT(0), .MAX_ROT(180)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
      .cmd_rot(cmd_rot), .cmd_immediate(cmd_immediate),
      .rotation(rotation), .set_rotation(set_rotation), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      for (int i = 0; i < 4; i++)
         if (set_rotation[i]) sc[i]++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strobe(output int n);
      n = -1;
      for (int k = 1; k <= 60; k++) begin
         step();
         if (set_rotation != 4'b0) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic send(input logic [1:0] c, input logic [7:0] r, input logic im);
      cmd_valid = 1'b1; cmd_ch = c; cmd_rot = r; cmd_immediate = im;
      step();
      cmd_valid = 1'b0; cmd_immediate = 1'b0;
   endtask

   function automatic int strobes();
      return sc[0] + sc[1] + sc[2] + sc[3];
   endfunction

   initial begin
      int n, s0, s2, s3, tot;
      reset_n = 1'b0; enable = 1'b0; cmd_valid = 1'b0;
      cmd_immediate = 1'b0; cmd_ch = '0; cmd_rot = '0;
      repeat (3) step();
      check("rst_rotation", rotation, 32'h5A5A5A5A);
      check("rst_strobe", set_rotation, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", cmd_ready, 0);

      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("init_strobe", set_rotation, 32'(1 << i));
         check("init_ready", cmd_ready, (i == 3) ? 1 : 0);
      end
      step();
      check("idle_strobe", set_rotation, 0);

      // immediate ch2 = 30
      send(2'd2, 8'd30, 1'b1);
      check("imm_rotation", rotation, 32'h5A1E5A5A);
      check("imm_strobe", set_rotation, 4'b0100);
      check("imm_busy", busy, 0);
      check("imm_ready", cmd_ready, 0);
      step();
      check("imm_strobe_end", set_rotation, 0);
      check("imm_ready_back", cmd_ready, 1);

      // clamp option: ch3 = 200 immediate
      send(2'd3, 8'd200, 1'b1);
      check("lim_rot3", rotation[31:24], EXP_LIM);
      check("lim_strobe", set_rotation, 4'b1000);
      step();

      // ramp ch1 90 -> 100 with step 4
      send(2'd1, 8'd100, 1'b0);
      check("ramp_busy", busy, 4'b0010);
      check("ramp_ready", cmd_ready, 1);
      check("ramp_no_jump", rotation[15:8], 8'd90);
      s0 = sc[0]; s2 = sc[2]; s3 = sc[3];
      enable = 1'b1;
      wait_strobe(n);
      check("ramp1_latency", n, 13);
      check("ramp1_strobe", set_rotation, 4'b0010);
      check("ramp1_rot", rotation[15:8], 8'd94);
      wait_strobe(n);
      check("ramp2_latency", n, 10);
      check("ramp2_rot", rotation[15:8], 8'd98);
      wait_strobe(n);
      check("ramp3_latency", n, 10);
      check("ramp3_rot", rotation[15:8], 8'd100);
      check("ramp3_busy", busy, 0);
      repeat (20) step();
      check("ramp_other_strobes", sc[0] + sc[2] + sc[3], s0 + s2 + s3);
      enable = 1'b0;
      repeat (3) step();
      check("scan_done_ready", cmd_ready, 1);

      // command in the cycle a tick is pending: command first, scan next
      enable = 1'b1;
      repeat (10) step();
      send(2'd0, 8'd95, 1'b0);
      check("cont_cmd_won", cmd_ready, 1);
      check("cont_busy", busy, 4'b0001);
      step();
      check("cont_scan_start", cmd_ready, 0);
      step();
      check("cont_strobe", set_rotation, 4'b0001);
      check("cont_rot0", rotation[7:0], 8'd94);
      repeat (15) step();
      enable = 1'b0;
      repeat (5) step();
      check("cont_all_rot", rotation, {EXP_LIM, 24'h1E645F});

      // underflow boundary: cur 3, target 0, step 4
      send(2'd0, 8'd3, 1'b1);
      step();
      send(2'd0, 8'd0, 1'b0);
      check("uf_busy", busy, 4'b0001);
      enable = 1'b1;
      wait_strobe(n);
      check("uf_latency", n, 12);
      check("uf_strobe", set_rotation, 4'b0001);
      check("uf_rot0", rotation[7:0], 8'd0);
      check("uf_busy_done", busy, 0);

      // enable low for 50 cycles: commands land, nothing ramps
      enable = 1'b0;
      repeat (5) step();
      send(2'd1, 8'd60, 1'b0);
      tot = strobes();
      repeat (50) step();
      check("dis_strobes", strobes(), tot);
      check("dis_rot1", rotation[15:8], 8'd100);
      check("dis_busy", busy, 4'b0010);
      check("dis_ready", cmd_ready, 1);

      // reset during a strobe cuts it at once
      send(2'd2, 8'd77, 1'b1);
      check("mid_strobe", set_rotation, 4'b0100);
      #1 reset_n = 1'b0;
      #1;
      check("mid_rst_strobe", set_rotation, 0);
      check("mid_rst_rotation", rotation, 32'h5A5A5A5A);
      check("mid_rst_ready", cmd_ready, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
